// File: rtl/led_status_ctrl.sv
// Status-LED engine: prescaled flow-light bank (Johnson/rotate/bounce/static) plus
// pulse-stretched activity LEDs fed from asynchronous toggle lines.
module led_status_ctrl #(
  parameter int   N_FLOW   = 6,
  parameter int   N_ACT    = 2,
  parameter int   PRESC_W  = 22,
  parameter int   STRETCH  = 1000000,
  parameter logic ACT_IDLE = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [1:0]        mode,
  input  logic [N_FLOW-1:0] static_val,
  input  logic [N_ACT-1:0]  act_in,
  output logic [N_FLOW-1:0] flow_led,
  output logic [N_ACT-1:0]  act_led,
  output logic              tick
);

  typedef enum logic [1:0] {
    MODE_JOHNSON = 2'd0,
    MODE_ROTATE  = 2'd1,
    MODE_BOUNCE  = 2'd2,
    MODE_STATIC  = 2'd3
  } mode_e;

  localparam int                CW        = $clog2(STRETCH + 1);
  localparam logic [CW-1:0]     STRETCH_C = CW'(STRETCH);
  localparam logic [N_FLOW-1:0] FLOW_ONE  = {{(N_FLOW-1){1'b0}}, 1'b1};
  localparam logic              DIR_UP    = 1'b0;
  localparam logic              DIR_DOWN  = 1'b1;

  logic [PRESC_W-1:0] r_presc;
  mode_e              r_mode_q;
  logic               r_dir;
  logic [N_FLOW-1:0]  r_flow;

  mode_e              w_mode;
  logic               w_reload;
  logic               w_tick;
  logic [N_FLOW-1:0]  w_shl;
  logic [N_FLOW-1:0]  w_shr;

  assign w_mode   = mode_e'(mode);
  assign w_reload = (w_mode != r_mode_q);
  assign w_tick   = &r_presc;
  assign w_shl    = {r_flow[N_FLOW-2:0], 1'b0};
  assign w_shr    = {1'b0, r_flow[N_FLOW-1:1]};

  // A mode change restarts the pattern from its seed and swallows any coincident tick.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_presc  <= '0;
      r_mode_q <= MODE_JOHNSON;
      r_dir    <= DIR_UP;
      r_flow   <= '0;
    end else begin
      r_mode_q <= w_mode;
      if (w_reload) begin
        r_presc <= '0;
        r_dir   <= DIR_UP;
        case (w_mode)
          MODE_JOHNSON: r_flow <= '0;
          MODE_ROTATE:  r_flow <= FLOW_ONE;
          MODE_BOUNCE:  r_flow <= FLOW_ONE;
          MODE_STATIC:  r_flow <= r_flow;
        endcase
      end else begin
        r_presc <= r_presc + 1'b1;
        if (w_tick) begin
          case (r_mode_q)
            MODE_JOHNSON: r_flow <= {r_flow[N_FLOW-2:0], ~r_flow[N_FLOW-1]};
            MODE_ROTATE:  r_flow <= {r_flow[N_FLOW-2:0], r_flow[N_FLOW-1]};
            MODE_BOUNCE: begin
              if (r_dir == DIR_UP) begin
                r_flow <= w_shl;
                if (w_shl[N_FLOW-1]) r_dir <= DIR_DOWN;
              end else begin
                r_flow <= w_shr;
                if (w_shr[0]) r_dir <= DIR_UP;
              end
            end
            MODE_STATIC:  r_flow <= r_flow;
          endcase
        end
      end
    end
  end

  assign flow_led = (r_mode_q == MODE_STATIC) ? static_val : r_flow;
  assign tick     = w_tick;

  logic [N_ACT-1:0] r_s1;
  logic [N_ACT-1:0] r_s2;
  logic [N_ACT-1:0] r_s3;
  logic [CW-1:0]    r_cnt [N_ACT];
  logic [N_ACT-1:0] w_edge;

  assign w_edge = r_s2 ^ r_s3;

  // Any toggle reloads the full on-time, even while the LED is already lit.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_s1 <= {N_ACT{ACT_IDLE}};
      r_s2 <= {N_ACT{ACT_IDLE}};
      r_s3 <= {N_ACT{ACT_IDLE}};
      for (int i = 0; i < N_ACT; i++) r_cnt[i] <= '0;
    end else begin
      r_s1 <= act_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      for (int i = 0; i < N_ACT; i++) begin
        if (w_edge[i])            r_cnt[i] <= STRETCH_C;
        else if (r_cnt[i] != '0)  r_cnt[i] <= r_cnt[i] - 1'b1;
      end
    end
  end

  always_comb begin
    act_led = '0;
    for (int i = 0; i < N_ACT; i++) act_led[i] = (r_cnt[i] != '0);
  end

endmodule

// File: tb/tb_led_status_ctrl.sv
// Directed bench for led_status_ctrl with N_FLOW=4, PRESC_W=3, STRETCH=5.
module tb_led_status_ctrl;

  logic       clk;
  logic       rstn;
  logic [1:0] mode;
  logic [3:0] static_val;
  logic [1:0] act_in;
  logic [3:0] flow_led;
  logic [1:0] act_led;
  logic       tick;

  int n_pass;
  int n_total;

  led_status_ctrl #(
    .N_FLOW  (4),
    .N_ACT   (2),
    .PRESC_W (3),
    .STRETCH (5),
    .ACT_IDLE(1'b1)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .mode      (mode),
    .static_val(static_val),
    .act_in    (act_in),
    .flow_led  (flow_led),
    .act_led   (act_led),
    .tick      (tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are then stable and inputs may be changed.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; mode = 2'd0; static_val = 4'b0000; act_in = 2'b11;
    step(); step();
    n_total++;
    if (flow_led !== 4'b0000) $display("FAIL reset_flow got=%b exp=0000", flow_led); else n_pass++;
    n_total++;
    if (act_led !== 2'b00) $display("FAIL reset_act got=%b exp=00", act_led); else n_pass++;
    n_total++;
    if (tick !== 1'b0) $display("FAIL reset_tick got=%b exp=0", tick); else n_pass++;
    rstn = 1'b1;
  endtask

  task automatic test_johnson();
    logic [3:0] exp_seq [9];
    exp_seq = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110,
                4'b1100, 4'b1000, 4'b0000, 4'b0001};
    for (int c = 1; c <= 7; c++) begin
      step();
      n_total++;
      if (tick !== (c == 7)) $display("FAIL first_tick cyc=%0d got=%b exp=%b", c, tick, (c == 7));
      else n_pass++;
    end
    step();
    n_total++;
    if (flow_led !== exp_seq[0]) $display("FAIL johnson_0 got=%b exp=%b", flow_led, exp_seq[0]); else n_pass++;
    for (int s = 1; s < 9; s++) begin
      repeat (8) step();
      n_total++;
      if (flow_led !== exp_seq[s]) $display("FAIL johnson_%0d got=%b exp=%b", s, flow_led, exp_seq[s]);
      else n_pass++;
    end
  endtask

  task automatic test_mode_switch();
    logic [3:0] exp_seq [4];
    exp_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    repeat (8) step();
    repeat (3) step();
    mode = 2'd1;
    step();
    n_total++;
    if (flow_led !== 4'b0001) $display("FAIL rotate_seed got=%b exp=0001", flow_led); else n_pass++;
    repeat (6) step();
    n_total++;
    if (tick !== 1'b0) $display("FAIL restart_no_early_tick got=%b exp=0", tick); else n_pass++;
    step();
    n_total++;
    if (tick !== 1'b1) $display("FAIL restart_tick got=%b exp=1", tick); else n_pass++;
    step();
    n_total++;
    if (flow_led !== exp_seq[0]) $display("FAIL rotate_0 got=%b exp=%b", flow_led, exp_seq[0]); else n_pass++;
    for (int s = 1; s < 4; s++) begin
      repeat (8) step();
      n_total++;
      if (flow_led !== exp_seq[s]) $display("FAIL rotate_%0d got=%b exp=%b", s, flow_led, exp_seq[s]);
      else n_pass++;
    end
  endtask

  task automatic test_bounce();
    logic [3:0] exp_seq [7];
    exp_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    mode = 2'd2;
    step();
    n_total++;
    if (flow_led !== 4'b0001) $display("FAIL bounce_seed got=%b exp=0001", flow_led); else n_pass++;
    for (int s = 0; s < 7; s++) begin
      repeat (8) step();
      n_total++;
      if (flow_led !== exp_seq[s]) $display("FAIL bounce_%0d got=%b exp=%b", s, flow_led, exp_seq[s]);
      else n_pass++;
    end
    repeat (7) step();
    n_total++;
    if (tick !== 1'b1) $display("FAIL bounce_tick got=%b exp=1", tick); else n_pass++;
    mode = 2'd1;
    step();
    n_total++;
    if (flow_led !== 4'b0001) $display("FAIL reload_beats_tick got=%b exp=0001", flow_led); else n_pass++;
    n_total++;
    if (tick !== 1'b0) $display("FAIL reload_presc_clear got=%b exp=0", tick); else n_pass++;
  endtask

  task automatic test_static();
    mode = 2'd3; static_val = 4'b1010;
    step();
    n_total++;
    if (flow_led !== 4'b1010) $display("FAIL static_show got=%b exp=1010", flow_led); else n_pass++;
    repeat (8) step();
    n_total++;
    if (flow_led !== 4'b1010) $display("FAIL static_hold got=%b exp=1010", flow_led); else n_pass++;
    static_val = 4'b0101;
    #1;
    n_total++;
    if (flow_led !== 4'b0101) $display("FAIL static_comb got=%b exp=0101", flow_led); else n_pass++;
    mode = 2'd0;
    step();
    n_total++;
    if (flow_led !== 4'b0000) $display("FAIL static_to_johnson got=%b exp=0000", flow_led); else n_pass++;
    repeat (8) step();
    n_total++;
    if (flow_led !== 4'b0001) $display("FAIL johnson_resume_0 got=%b exp=0001", flow_led); else n_pass++;
    repeat (8) step();
    n_total++;
    if (flow_led !== 4'b0011) $display("FAIL johnson_resume_1 got=%b exp=0011", flow_led); else n_pass++;
  endtask

  task automatic test_activity();
    logic [1:0] exp_act;
    act_in = 2'b10;
    for (int i = 0; i <= 7; i++) begin
      step();
      exp_act = (i >= 2 && i <= 6) ? 2'b01 : 2'b00;
      n_total++;
      if (act_led !== exp_act) $display("FAIL act_single edge+%0d got=%b exp=%b", i, act_led, exp_act);
      else n_pass++;
    end
    act_in = 2'b01;
    step(); step(); step();
    n_total++;
    if (act_led !== 2'b11) $display("FAIL act_both got=%b exp=11", act_led); else n_pass++;
    repeat (6) step();
    n_total++;
    if (act_led !== 2'b00) $display("FAIL act_both_off got=%b exp=00", act_led); else n_pass++;
  endtask

  task automatic test_extend_reset();
    logic [1:0] exp_act;
    act_in = 2'b00;
    for (int i = 0; i <= 12; i++) begin
      step();
      exp_act = (i >= 2 && i <= 11) ? 2'b01 : 2'b00;
      n_total++;
      if (act_led !== exp_act) $display("FAIL act_extend edge+%0d got=%b exp=%b", i, act_led, exp_act);
      else n_pass++;
      if (i == 4) act_in = 2'b01;
    end
    mode = 2'd1;
    act_in = 2'b00;
    step(); step(); step();
    n_total++;
    if (act_led !== 2'b01 || flow_led !== 4'b0001)
      $display("FAIL pre_reset_lit act=%b flow=%b exp act=01 flow=0001", act_led, flow_led);
    else n_pass++;
    rstn = 1'b0;
    step();
    n_total++;
    if (act_led !== 2'b00) $display("FAIL midrun_reset_act got=%b exp=00", act_led); else n_pass++;
    n_total++;
    if (flow_led !== 4'b0000) $display("FAIL midrun_reset_flow got=%b exp=0000", flow_led); else n_pass++;
    n_total++;
    if (tick !== 1'b0) $display("FAIL midrun_reset_tick got=%b exp=0", tick); else n_pass++;
    rstn = 1'b1;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    test_reset();
    test_johnson();
    test_mode_switch();
    test_bounce();
    test_static();
    test_activity();
    test_extend_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
